// File: rtl/seq_divider_32bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_32bit
// Purpose  : Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//            One conditional subtract per clock, WIDTH iterations per op.
//            Divide-by-zero and signed overflow finish in a single cycle.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            start            - request, accepted only while ready=1
//            op[1:0]          - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//            dividend,divisor - operands, sampled at acceptance
//            flush            - abort an in-flight operation
//            ready            - high while idle
//            done             - one-cycle pulse, result valid
//            result           - quotient or remainder as selected by op
//            div_by_zero      - divisor was zero (qualified by done)
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [1:0]       c_IDLE = 2'd0;
  localparam logic [1:0]       c_CALC = 2'd1;
  localparam logic [1:0]       c_DONE = 2'd2;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sel_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_result;
  logic             r_dbz;

  // ---------------- acceptance-time decode ----------------
  logic             w_accept;
  logic             w_signed;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div0;
  logic             w_ovf;

  // flush outranks start in IDLE
  assign w_accept = (r_state == c_IDLE) && start && !flush;
  assign w_signed = ~op[0];
  assign w_neg_a  = w_signed & dividend[WIDTH-1];
  assign w_neg_b  = w_signed & divisor[WIDTH-1];
  // -MIN wraps back to MIN, which is the correct magnitude read as unsigned
  assign w_mag_a  = w_neg_a ? -dividend : dividend;
  assign w_mag_b  = w_neg_b ? -divisor  : divisor;
  assign w_div0   = (divisor == '0);
  assign w_ovf    = w_signed && (dividend == c_MIN) && (divisor == '1);

  // ---------------- one restoring step ----------------
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  // rem < divisor always holds, so the trial's top bit is a clean borrow flag
  assign w_borrow  = w_trial[WIDTH];
  assign w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (w_accept) w_next_state = (w_div0 || w_ovf) ? c_DONE : c_CALC;
      c_CALC: begin
        if (flush)                  w_next_state = c_IDLE;
        else if (r_count == c_LAST) w_next_state = c_DONE;
      end
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = (r_state == c_IDLE);
    done  = (r_state == c_DONE);
  end

  assign result      = r_result;
  assign div_by_zero = r_dbz;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= w_mag_a;
      r_dvs     <= w_mag_b;
      r_sel_rem <= op[1];
      r_neg_q   <= w_neg_a ^ w_neg_b;
      r_neg_r   <= w_neg_a;
      // special cases publish their result now and skip CALC entirely
      if (w_div0) begin
        r_result <= op[1] ? dividend : '1;
        r_dbz    <= 1'b1;
      end else if (w_ovf) begin
        r_result <= op[1] ? '0 : c_MIN;
        r_dbz    <= 1'b0;
      end
    end else if (r_state == c_CALC && !flush) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_count <= r_count + CNT_W'(1);
      if (r_count == c_LAST) begin
        r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
        r_dbz    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_32bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider_32bit
// Purpose  : Self-checking bench for seq_divider_32bit. Directed vector table
//            plus hand-written sequences for flush, reset and start handling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  seq_divider_32bit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .ready(ready), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    int          k;     // edge index (E0 = 0) after which done is visible
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic z, input int k, input string nm);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.res = r; v.dbz = z; v.k = k; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Watch n cycles and require no done and ready high throughout.
  task automatic quiet(input string nm, input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done || !ready) bad = 1'b1;
    end
    check32(nm, {31'b0, bad}, 32'd0);
  endtask

  // Wait for done after an acceptance edge already passed; returns edge index.
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int k;
    @(negedge clk);
    check32({v.name, " ready"}, {31'b0, ready}, 32'd1);
    op = v.op; dividend = v.a; divisor = v.b; start = 1'b1;
    @(posedge clk); #1;                  // E0
    start = 1'b0;
    dividend = 32'hDEAD_BEEF;            // operands must no longer matter
    divisor  = 32'h0000_0001;
    wait_done(k);
    check32({v.name, " done_edge"}, k, v.k);
    check32({v.name, " result"}, result, v.res);
    check32({v.name, " dbz"}, {31'b0, div_by_zero}, {31'b0, v.dbz});
    last_res = v.res;
    @(posedge clk); #1;
    check32({v.name, " pulse"}, {30'b0, done, ready}, 32'd1);
  endtask

  initial begin
    int k;
    add_vec(2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 32, "divu_100_7");
    add_vec(2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 32, "remu_100_7");
    add_vec(2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 32, "div_m7_2");
    add_vec(2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 32, "rem_m7_2");
    add_vec(2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 32, "rem_7_m2");
    add_vec(2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 32, "div_m100_m7");
    add_vec(2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0, 32, "rem_m100_m7");
    add_vec(2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 32, "div_min_2");
    add_vec(2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 0,  "div_ovf");
    add_vec(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 0,  "rem_ovf");
    add_vec(2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 0,  "divu_5_0");
    add_vec(2'b10, 32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7,  1'b1, 0,  "rem_m9_0");
    add_vec(2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 32, "divu_max_1");
    add_vec(2'b01, 32'd3,          32'hFFFF_FFFF,  32'd0,          1'b0, 32, "divu_3_max");
    add_vec(2'b11, 32'd3,          32'hFFFF_FFFF,  32'd3,          1'b0, 32, "remu_3_max");

    // reset state while rst is held
    #1;
    check32("reset_outputs", {29'b0, ready, done, div_by_zero}, 32'b100);
    check32("reset_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // flush at CALC count 10
    @(negedge clk); op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check32("flush_state", {30'b0, done, ready}, 32'd1);
    check32("flush_result", result, last_res);
    quiet("flush_quiet", 40);

    // reset pulse at CALC count 20
    @(negedge clk); op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check32("midrst_outputs", {29'b0, ready, done, div_by_zero}, 32'b100);
    check32("midrst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    quiet("midrst_quiet", 40);

    begin
      vec_t v;
      v.op = 2'b01; v.a = 32'd9; v.b = 32'd3; v.res = 32'd3; v.dbz = 1'b0; v.k = 32;
      v.name = "divu_9_3";
      run_op(v);
    end

    // flush together with start in IDLE: not accepted
    @(negedge clk); op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check32("flush_start_idle", {31'b0, ready}, 32'd1);
    quiet("flush_start_quiet", 40);

    // flush during DONE: the pulse still completes
    @(negedge clk); op = 2'b01; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b1;
    check32("flush_done_pulse", {30'b0, done, div_by_zero}, 32'b11);
    @(posedge clk); #1; flush = 1'b0;
    check32("flush_done_idle", {30'b0, done, ready}, 32'd1);

    // start held during CALC: no second op
    @(negedge clk); op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    wait_done(k);
    start = 1'b0;
    check32("hold_calc_edge", k, 32);
    check32("hold_calc_result", result, 32'd14);
    @(posedge clk); #1;
    quiet("hold_calc_quiet", 40);

    // start held through DONE: next op accepted in the following IDLE cycle
    @(negedge clk); op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;                  // E0
    dividend = 32'd9; divisor = 32'd3;   // picked up by the second op only
    wait_done(k);
    check32("b2b_first_edge", k, 32);
    check32("b2b_first_result", result, 32'd14);
    @(posedge clk); #1;                  // E33: back in IDLE
    check32("b2b_idle", {30'b0, done, ready}, 32'd1);
    @(posedge clk); #1;                  // E34: second acceptance
    start = 1'b0;
    check32("b2b_accept", {31'b0, ready}, 32'd0);
    wait_done(k);
    check32("b2b_second_edge", k, 32);
    check32("b2b_second_result", result, 32'd3);
    @(posedge clk); #1;
    check32("b2b_end", {30'b0, done, ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
